mips_cpu_load_store_unit: RTL

Load/store unit between the CPU datapath's memory stage and the Harvard data port of `mips_cpu_memory`. It accepts one byte-addressed load/store request at a time and issues word-aligned, single-cycle reads and writes to the word-wide data port, which has no byte enables. It performs sign/zero extension for loads, read-modify-write for sub-word stores, and alignment checking.

---
 rtl/mips_cpu_lsu_pkg.sv | 58 +++++
 rtl/mips_cpu_lsu_align.sv | 73 +++++++
 rtl/mips_cpu_load_store_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Optional LWL/LWR support is enabled by defining MIPS_LSU_LWLR_EN.
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LBU = 4'd1,
        LSU_LH  = 4'd2,
        LSU_LHU = 4'd3,
        LSU_LW  = 4'd4,
        LSU_SB  = 4'd5,
        LSU_SH  = 4'd6,
        LSU_SW  = 4'd7,
        LSU_LWL = 4'd8,
        LSU_LWR = 4'd9
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_LH,
            LSU_LHU, LSU_LW: return 1'b1;
`ifdef MIPS_LSU_LWLR_EN
            LSU_LWL, LSU_LWR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            LSU_SB, LSU_SH, LSU_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // LWL/LWR and byte ops accept any offset.
    function automatic logic misaligned(
        input logic [3:0] op,
        input logic [1:0] off
    );
        case (op)
            LSU_LW, LSU_SW: return off != 2'd0;
            LSU_LH, LSU_LHU,
            LSU_SH: return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational load extract/extend, sub-word store merge and
// LWL/LWR merge (the latter only with MIPS_LSU_LWLR_EN defined).
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
`ifdef MIPS_LSU_LWLR_EN
    input  logic [31:0] rt_i,
`endif
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [31:0] shr;
    assign shr = rdata_i >> {off_i, 3'b000};

`ifdef MIPS_LSU_LWLR_EN
    logic [31:0] lwl_mask;
    logic [31:0] lwr_keep;

    // rt bytes preserved by LWL; nothing survives at offset 3.
    always_comb begin
        lwl_mask = 32'h0;
        unique case (off_i)
            2'd0: lwl_mask = 32'h00FF_FFFF;
            2'd1: lwl_mask = 32'h0000_FFFF;
            2'd2: lwl_mask = 32'h0000_00FF;
            2'd3: lwl_mask = 32'h0000_0000;
        endcase
    end

    assign lwr_keep = ~(32'hFFFF_FFFF >> {off_i, 3'b000});
`endif

    // Load result selection and extension.
    always_comb begin
        load_o = 32'h0;
        case (op_i)
            LSU_LB:  load_o = {{24{shr[7]}}, shr[7:0]};
            LSU_LBU: load_o = {24'h0, shr[7:0]};
            LSU_LH:  load_o = {{16{shr[15]}}, shr[15:0]};
            LSU_LHU: load_o = {16'h0, shr[15:0]};
            LSU_LW:  load_o = rdata_i;
`ifdef MIPS_LSU_LWLR_EN
            LSU_LWL: load_o = (rdata_i << {~off_i, 3'b000})
                            | (rt_i & lwl_mask);
            LSU_LWR: load_o = shr | (rt_i & lwr_keep);
`endif
            default: load_o = 32'h0;
        endcase
    end

    // Replace the addressed byte/halfword of the read word.
    always_comb begin
        merge_o = word_i;
        if (op_i == LSU_SH) begin
            if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
            else          merge_o[15:0]  = wdata_i[15:0];
        end else begin
            unique case (off_i)
                2'd0: merge_o[7:0]   = wdata_i[7:0];
                2'd1: merge_o[15:8]  = wdata_i[7:0];
                2'd2: merge_o[23:16] = wdata_i[7:0];
                2'd3: merge_o[31:24] = wdata_i[7:0];
            endcase
        end
    end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Load/store unit bridging the memory stage to a word-wide data port.
// Define MIPS_LSU_LWLR_EN to enable LWL/LWR.
module mips_cpu_load_store_unit
    import mips_cpu_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    lsu_state_t  state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic        accept;
    logic        req_err;
    logic [31:0] load_res;
    logic [31:0] merge_res;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign req_err   = !(is_load(req_op) || is_store(req_op))
                     || misaligned(req_op, req_addr[1:0]);

`ifdef MIPS_LSU_LWLR_EN
    logic [31:0] rt_q;

    // Old rt value for the LWL/LWR merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rt_q <= 32'h0;
        else if (accept) rt_q <= req_rt;
    end
`else
    logic unused_rt;
    assign unused_rt = ^req_rt;
`endif

    mips_cpu_lsu_align u_align (
        .op_i    (op_q),
        .off_i   (addr_q[1:0]),
        .rdata_i (data_readdata),
        .word_i  (word_q),
        .wdata_i (wdata_q),
`ifdef MIPS_LSU_LWLR_EN
        .rt_i    (rt_q),
`endif
        .load_o  (load_res),
        .merge_o (merge_res)
    );

    // Next state and response registers.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    resp_data_d = 32'h0;
                    resp_err_d  = req_err;
                    if (req_err)              state_d = ST_RESP;
                    else if (is_load(req_op)) state_d = ST_LOAD;
                    else if (req_op == LSU_SW) state_d = ST_STORE;
                    else                      state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                resp_data_d = load_res;
                state_d     = ST_RESP;
            end
            ST_STORE:  state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Request capture and RMW read-word capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_RMW_RD) word_q <= data_readdata;
        end
    end

    assign data_address = {addr_q[31:2], 2'b00};
    assign data_read    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign data_write   = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
    assign data_writedata = (state_q == ST_STORE)  ? wdata_q   :
                            (state_q == ST_RMW_WR) ? merge_res :
                            32'h0;

    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
